// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage: memory map, redirect
// classes and fetch FSM states.
package mips_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_4FFC;

    // Numeric order is the priority order; higher class wins.
    typedef enum logic [1:0] {
        ClsNone   = 2'd0,
        ClsBranch = 2'd1,
        ClsEret   = 2'd2,
        ClsIrq    = 2'd3
    } redir_class_t;

    typedef enum logic {
        StRun  = 1'b0,
        StPend = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage control/status bundle between the decode/hazard/CP0 side
// (master) and the PC fetch unit (slave).
interface pc_fetch_if;

    logic        StallF;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        EretD;
    logic [31:0] EPC;
    logic        InterruptRequest;
    logic        CtrlInstrD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        AtDelaySlotF;
    logic        CancelF;
    logic        RedirectPending;

    modport master (
        output StallF, BranchTakenD, BranchTargetD, EretD, EPC, InterruptRequest, CtrlInstrD,
        input  PCF, PCPlus4F, AtDelaySlotF, CancelF, RedirectPending
    );

    modport slave (
        input  StallF, BranchTakenD, BranchTargetD, EretD, EPC, InterruptRequest, CtrlInstrD,
        output PCF, PCPlus4F, AtDelaySlotF, CancelF, RedirectPending
    );

endinterface

// File: rtl/redirect_arbiter.sv
// Picks the highest-class redirect among this cycle's requests and the latched
// pending entry; a same-cycle request wins ties against the pending one.
module redirect_arbiter
    import mips_pkg::*;
(
    input  logic         irq,
    input  logic         eret,
    input  logic         branch,
    input  logic [31:0]  epc,
    input  logic [31:0]  branch_target,
    input  logic         pend_valid,
    input  redir_class_t pend_class,
    input  logic [31:0]  pend_target,
    output logic         winner_valid,
    output redir_class_t winner_class,
    output logic [31:0]  winner_target
);

    redir_class_t req_class;
    logic [31:0]  req_target;

    always_comb begin
        req_class  = ClsNone;
        req_target = '0;
        if (irq) begin
            req_class  = ClsIrq;
            req_target = EXC_VECTOR;
        end else if (eret) begin
            req_class  = ClsEret;
            req_target = epc;
        end else if (branch) begin
            req_class  = ClsBranch;
            req_target = branch_target;
        end
    end

    always_comb begin
        if (pend_valid && (pend_class > req_class)) begin
            winner_class  = pend_class;
            winner_target = pend_target;
        end else begin
            winner_class  = req_class;
            winner_target = req_target;
        end
        winner_valid = (winner_class != ClsNone);
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter for the fetch stage: sequential fetch, prioritised redirects,
// and a pending slot that holds a redirect across hazard stalls.
module pc_fetch
    import mips_pkg::*;
(
    input logic       clk,
    input logic       reset,
    pc_fetch_if.slave fif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_target_q, pend_target_d;
    redir_class_t pend_class_q, pend_class_d;
    logic [31:0]  pc_plus4;

    logic         winner_valid;
    redir_class_t winner_class;
    logic [31:0]  winner_target;

    assign pc_plus4 = pc_q + 32'd4;

    redirect_arbiter u_arb (
        .irq           (fif.InterruptRequest),
        .eret          (fif.EretD),
        .branch        (fif.BranchTakenD),
        .epc           (fif.EPC),
        .branch_target (fif.BranchTargetD),
        .pend_valid    (state_q == StPend),
        .pend_class    (pend_class_q),
        .pend_target   (pend_target_q),
        .winner_valid  (winner_valid),
        .winner_class  (winner_class),
        .winner_target (winner_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= PC_RESET;
            pend_target_q <= '0;
            pend_class_q  <= ClsNone;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_class_q  <= pend_class_d;
        end
    end

    // In PEND the arbiter already applies the overwrite-if-not-lower rule,
    // so the winner is simply re-latched every stalled cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_class_d  = pend_class_q;
        unique case (state_q)
            StRun: begin
                if (!fif.StallF) begin
                    pc_d = winner_valid ? winner_target : pc_plus4;
                end else if (winner_valid) begin
                    pend_target_d = winner_target;
                    pend_class_d  = winner_class;
                    state_d       = StPend;
                end
            end
            StPend: begin
                if (!fif.StallF) begin
                    pc_d          = winner_target;
                    pend_target_d = '0;
                    pend_class_d  = ClsNone;
                    state_d       = StRun;
                end else begin
                    pend_target_d = winner_target;
                    pend_class_d  = winner_class;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        fif.PCF             = pc_q;
        fif.PCPlus4F        = pc_plus4;
        fif.CancelF         = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
        fif.AtDelaySlotF    = fif.CtrlInstrD & ~fif.CancelF;
        fif.RedirectPending = (state_q == StPend);
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, redirect priority, stall
// pending behaviour, misalignment/range cancel and asynchronous reset.
module tb_pc_fetch;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pc_fetch_if fif ();

    pc_fetch dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        fif.BranchTakenD     = 1'b0;
        fif.BranchTargetD    = 32'h0;
        fif.EretD            = 1'b0;
        fif.EPC              = 32'h0;
        fif.InterruptRequest = 1'b0;
        fif.CtrlInstrD       = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] t);
        fif.BranchTakenD  = 1'b1;
        fif.BranchTargetD = t;
    endtask

    initial begin
        reset      = 1'b1;
        fif.StallF = 1'b0;
        clear_req();
        fif.CtrlInstrD = 1'b1;
        #12;
        chk("rst_pcf", fif.PCF, 32'h3000);
        chk("rst_pc4", fif.PCPlus4F, 32'h3004);
        chk("rst_cancel", {31'b0, fif.CancelF}, 32'h0);
        chk("rst_pend", {31'b0, fif.RedirectPending}, 32'h0);
        chk("rst_ds", {31'b0, fif.AtDelaySlotF}, 32'h1);
        fif.CtrlInstrD = 1'b0;
        reset = 1'b0;
        #1;
        chk("seq0", fif.PCF, 32'h3000);
        tick(); chk("seq1", fif.PCF, 32'h3004);
        tick(); chk("seq2", fif.PCF, 32'h3008);
        tick(); chk("seq3", fif.PCF, 32'h300C);
        tick(); chk("seq4", fif.PCF, 32'h3010);

        // Taken branch with delay slot flag
        branch_to(32'h3100);
        fif.CtrlInstrD = 1'b1;
        #1;
        chk("br_ds", {31'b0, fif.AtDelaySlotF}, 32'h1);
        tick(); chk("br_pcf", fif.PCF, 32'h3100);
        clear_req();

        // Branch latched during a 3-cycle stall
        fif.StallF = 1'b1;
        branch_to(32'h3200);
        tick(); chk("st_hold0", fif.PCF, 32'h3100);
        chk("st_pend0", {31'b0, fif.RedirectPending}, 32'h1);
        clear_req();
        tick(); tick();
        chk("st_hold2", fif.PCF, 32'h3100);
        chk("st_pend2", {31'b0, fif.RedirectPending}, 32'h1);
        fif.StallF = 1'b0;
        tick(); chk("st_pcf", fif.PCF, 32'h3200);
        chk("st_pend_clr", {31'b0, fif.RedirectPending}, 32'h0);
        tick(); chk("st_seq", fif.PCF, 32'h3204);

        // Interrupt overwrites pending branch; a later branch is dropped
        fif.StallF = 1'b1;
        branch_to(32'h3200);
        tick();
        clear_req();
        fif.InterruptRequest = 1'b1;
        tick();
        clear_req();
        branch_to(32'h3300);
        tick();
        chk("irq_hold", fif.PCF, 32'h3204);
        clear_req();
        fif.StallF = 1'b0;
        tick(); chk("irq_over", fif.PCF, 32'h4180);

        // Same-cycle priority
        fif.InterruptRequest = 1'b1;
        fif.EretD            = 1'b1;
        fif.EPC              = 32'h3050;
        branch_to(32'h3100);
        tick(); chk("prio_all", fif.PCF, 32'h4180);
        fif.InterruptRequest = 1'b0;
        tick(); chk("prio_eret_br", fif.PCF, 32'h3050);
        clear_req();
        tick(); chk("prio_seq", fif.PCF, 32'h3054);
        fif.EretD = 1'b1;
        fif.EPC   = 32'h3050;
        tick(); chk("eret_only", fif.PCF, 32'h3050);
        clear_req();

        // Pending branch tie with same-cycle branch: new one wins
        fif.StallF = 1'b1;
        branch_to(32'h3500);
        tick();
        branch_to(32'h3600);
        fif.StallF = 1'b0;
        tick(); chk("tie_new", fif.PCF, 32'h3600);
        clear_req();

        // Misaligned and out-of-range targets
        branch_to(32'h3002);
        tick(); clear_req();
        chk("mis_pcf", fif.PCF, 32'h3002);
        chk("mis_cancel", {31'b0, fif.CancelF}, 32'h1);
        chk("mis_pc4", fif.PCPlus4F, 32'h3006);
        fif.CtrlInstrD = 1'b1;
        #1;
        chk("mis_ds", {31'b0, fif.AtDelaySlotF}, 32'h0);
        fif.CtrlInstrD = 1'b0;
        branch_to(32'h5000);
        tick(); clear_req();
        chk("oor_cancel", {31'b0, fif.CancelF}, 32'h1);
        branch_to(32'h4FFC);
        tick(); clear_req();
        chk("lim_cancel", {31'b0, fif.CancelF}, 32'h0);
        branch_to(32'hFFFF_FFFC);
        tick(); clear_req();
        chk("wrap_pc4", fif.PCPlus4F, 32'h0);
        chk("wrap_cancel", {31'b0, fif.CancelF}, 32'h1);
        tick(); chk("wrap_pcf", fif.PCF, 32'h0);

        // Asynchronous reset in PEND
        fif.StallF = 1'b1;
        branch_to(32'h3400);
        tick();
        chk("ar_pend", {31'b0, fif.RedirectPending}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("ar_pcf", fif.PCF, 32'h3000);
        chk("ar_pend_clr", {31'b0, fif.RedirectPending}, 32'h0);
        clear_req();
        fif.StallF = 1'b0;
        reset = 1'b0;
        tick(); chk("ar_no_stale", fif.PCF, 32'h3004);
        chk("ar_state", {31'b0, fif.RedirectPending}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
